quantize_row_sequencer: RTL and testbench

- Accepts one 8x8 block of 12-bit DCT coefficients (8 rows x 96 bits) over a valid/ready handshake and holds it stable.
- Drives the row-quantizer datapath with matrix_row 0..7 and captures each 10-bit-per-coefficient result row (plus 8-bit quality) after a fixed pipeline latency.
- Streams the result rows downstream through a credit-protected output FIFO with backpressure.
- Sits between the DCT stage and the zigzag/entropy stage.

---
 rtl/quantize_row_sequencer.sv | 172 +++++++++++++++++
 tb/tb_quantize_row_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quantize_row_sequencer.sv
// Holds one 8x8 coefficient block, issues its rows to the quantizer under a credit
// limit, and streams the captured result rows out through a small FIFO.
module quantize_row_sequencer #(
   parameter int QLAT  = 2,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_is_luminance,
   input  logic         in_quantize_off,
   input  logic [767:0] in_coeffs,
   output logic [767:0] q_dct_coeffs,
   output logic [7:0]   q_matrix_row,
   output logic         q_is_luminance,
   output logic         q_quantize_off,
   output logic         q_issue,
   input  logic [79:0]  q_out,
   input  logic [7:0]   q_quality,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [79:0]  out_data,
   output logic [7:0]   out_quality,
   output logic [2:0]   out_row,
   output logic         out_last,
   output logic         busy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + QLAT + 1);
   localparam int ENT_W = 92;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   generate
      if (QLAT < 1 || QLAT > 4 || DEPTH < QLAT + 2) begin : g_bad_params
         $fatal(1, "quantize_row_sequencer: illegal QLAT/DEPTH combination");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t             state_q, state_d;
   logic [2:0]         row_q, row_d;
   logic [767:0]       coeffs_q;
   logic               luma_q, qoff_q;
   logic [QLAT-1:0]    vld_q, vld_d;
   logic [2:0]         vrow_q [QLAT];
   logic [ENT_W-1:0]   mem_q [DEPTH];
   logic [ENT_W-1:0]   head;
   logic [PTR_W-1:0]   wr_q, rd_q;
   logic [CNT_W-1:0]   occ_q, inflight;
   logic               accept, issue, push, pop;

   // Rows issued but not yet written into the FIFO still hold a credit.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < QLAT; i++) begin
         inflight = inflight + CNT_W'(vld_q[i]);
      end
   end

   assign push      = vld_q[QLAT-1];
   assign out_valid = (occ_q != '0);
   assign pop       = out_valid && out_ready;
   assign head      = mem_q[rd_q];

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      accept   = 1'b0;
      issue    = 1'b0;
      in_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = !reset;
            accept   = in_valid && !reset;
            if (accept) begin
               row_d   = 3'd0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!reset && (occ_q + inflight < DEPTH_C)) begin
               issue = 1'b1;
               row_d = row_q + 3'd1;
               if (row_q == 3'd7) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && head[91]) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      vld_d[0] = issue;
      for (int i = 1; i < QLAT; i++) begin
         vld_d[i] = vld_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         row_q    <= 3'd0;
         coeffs_q <= '0;
         luma_q   <= 1'b0;
         qoff_q   <= 1'b0;
         vld_q    <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         occ_q    <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         vld_q   <= vld_d;
         if (accept) begin
            coeffs_q <= in_coeffs;
            luma_q   <= in_is_luminance;
            qoff_q   <= in_quantize_off;
         end
         if (push) begin
            wr_q <= (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
         end
         if (pop) begin
            rd_q <= (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   occ_q <= occ_q + 1'b1;
            2'b01:   occ_q <= occ_q - 1'b1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Row tags travel alongside the valid bits; FIFO storage needs no reset.
   always_ff @(posedge clock) begin
      vrow_q[0] <= row_q;
      for (int i = 1; i < QLAT; i++) begin
         vrow_q[i] <= vrow_q[i-1];
      end
      if (push) begin
         mem_q[wr_q] <= {(vrow_q[QLAT-1] == 3'd7), vrow_q[QLAT-1], q_quality, q_out};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (!(push && occ_q == DEPTH_C))
            else $error("quantize_row_sequencer: output FIFO overflow");
      end
   end

   assign q_dct_coeffs   = coeffs_q;
   assign q_matrix_row   = {5'd0, row_q};
   assign q_is_luminance = luma_q;
   assign q_quantize_off = qoff_q;
   assign q_issue        = issue;
   assign busy           = (state_q != S_IDLE);
   assign out_data       = out_valid ? head[79:0]  : '0;
   assign out_quality    = out_valid ? head[87:80] : '0;
   assign out_row        = out_valid ? head[90:88] : '0;
   assign out_last       = out_valid && head[91];

endmodule

// File: tb/tb_quantize_row_sequencer.sv
// Scoreboard bench for quantize_row_sequencer: a stand-in quantizer feeds results back,
// expected rows are queued at block accept and popped by an output monitor.
module tb_quantize_row_sequencer;

   localparam int QLAT = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic         reset;
   logic         in_valid, in_ready, in_is_luminance, in_quantize_off;
   logic [767:0] in_coeffs, q_dct_coeffs;
   logic [7:0]   q_matrix_row, q_quality, out_quality;
   logic         q_is_luminance, q_quantize_off, q_issue;
   logic [79:0]  q_out, out_data;
   logic         out_valid, out_ready, out_last, busy;
   logic [2:0]   out_row;

   logic         in_valid2, in_ready2, q_is_luminance2, q_quantize_off2, q_issue2;
   logic [767:0] in_coeffs2, q_dct_coeffs2;
   logic [7:0]   q_matrix_row2, q_quality2, out_quality2;
   logic [79:0]  q_out2, out_data2;
   logic         out_valid2, out_ready2, out_last2, busy2;
   logic [2:0]   out_row2;

   quantize_row_sequencer #(.QLAT(QLAT), .DEPTH(4)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_is_luminance(in_is_luminance), .in_quantize_off(in_quantize_off),
      .in_coeffs(in_coeffs), .q_dct_coeffs(q_dct_coeffs), .q_matrix_row(q_matrix_row),
      .q_is_luminance(q_is_luminance), .q_quantize_off(q_quantize_off), .q_issue(q_issue),
      .q_out(q_out), .q_quality(q_quality), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_quality(out_quality), .out_row(out_row),
      .out_last(out_last), .busy(busy));

   quantize_row_sequencer #(.QLAT(1), .DEPTH(3)) dut2 (
      .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_is_luminance(1'b1), .in_quantize_off(1'b0),
      .in_coeffs(in_coeffs2), .q_dct_coeffs(q_dct_coeffs2), .q_matrix_row(q_matrix_row2),
      .q_is_luminance(q_is_luminance2), .q_quantize_off(q_quantize_off2), .q_issue(q_issue2),
      .q_out(q_out2), .q_quality(q_quality2), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_data(out_data2), .out_quality(out_quality2), .out_row(out_row2),
      .out_last(out_last2), .busy(busy2));

   // Stand-in quantizer: pass-through, or shift right by 1 (luma) / 2 (chroma).
   function automatic logic [79:0] qf(input logic [767:0] blk, input logic [2:0] r,
                                      input logic luma, input logic off);
      logic [79:0] res;
      logic [11:0] c;
      res = '0;
      for (int i = 0; i < 8; i++) begin
         c = blk[96*int'(r) + 12*i +: 12];
         res[10*i +: 10] = off ? c[9:0] : (luma ? c[10:1] : c[11:2]);
      end
      return res;
   endfunction

   function automatic logic [7:0] qq(input logic [2:0] r, input logic luma, input logic off);
      return {luma, off, 3'b101, r};
   endfunction

   logic [79:0] m_d [QLAT];
   logic [7:0]  m_q [QLAT];
   logic [79:0] m2_d;
   logic [7:0]  m2_q;
   always @(posedge clock) begin
      m_d[0] <= qf(q_dct_coeffs, q_matrix_row[2:0], q_is_luminance, q_quantize_off);
      m_q[0] <= qq(q_matrix_row[2:0], q_is_luminance, q_quantize_off);
      for (int i = 1; i < QLAT; i++) begin
         m_d[i] <= m_d[i-1];
         m_q[i] <= m_q[i-1];
      end
      m2_d <= qf(q_dct_coeffs2, q_matrix_row2[2:0], q_is_luminance2, q_quantize_off2);
      m2_q <= qq(q_matrix_row2[2:0], q_is_luminance2, q_quantize_off2);
   end
   assign q_out      = m_d[QLAT-1];
   assign q_quality  = m_q[QLAT-1];
   assign q_out2     = m2_d;
   assign q_quality2 = m2_q;

   typedef struct packed {
      logic [79:0] d;
      logic [7:0]  q;
      logic [2:0]  r;
      logic        l;
   } exp_t;
   exp_t sb[$];

   int checks = 0, errors = 0, cyc = 0;
   int t_acc, issue_cnt, t_issue_first, t_issue_last, t_last_out;
   int t_acc2, t_last2, exp_row2;
   logic [767:0] cur_coeffs, blk2;
   logic         cur_luma, cur_off, prev_stall, rand_mode;
   logic [95:0]  prev_word;
   logic [79:0]  last_data;
   logic [7:0]   last_qual;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", nm);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Output monitor and scoreboard; expected rows are queued at the accept handshake.
   initial begin
      prev_stall = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            sb.delete();
            prev_stall = 1'b0;
         end else begin
            if (busy) begin
               chk("in_ready_low_while_busy", 96'(in_ready), 96'(0));
               chk("q_coeffs_held", 96'(q_dct_coeffs == cur_coeffs), 96'(1));
               chk("q_luma_held", 96'(q_is_luminance), 96'(cur_luma));
               chk("q_off_held", 96'(q_quantize_off), 96'(cur_off));
            end
            if (q_issue) begin
               chk("issue_row", 96'(q_matrix_row), 96'(issue_cnt));
               if (issue_cnt == 0) t_issue_first = cyc + 1;
               if (issue_cnt == 7) t_issue_last = cyc + 1;
               issue_cnt++;
            end
            if (prev_stall)
               chk("stall_stable", 96'({out_valid, out_row, out_last, out_quality, out_data}),
                   prev_word);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_row actual=%0d required=none", out_row);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("out_row", 96'(out_row), 96'(e.r));
                  chk("out_data", 96'(out_data), 96'(e.d));
                  chk("out_quality", 96'(out_quality), 96'(e.q));
                  chk("out_last", 96'(out_last), 96'(e.l));
               end
               last_data = out_data;
               last_qual = out_quality;
               if (out_last) t_last_out = cyc + 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = 96'({out_valid, out_row, out_last, out_quality, out_data});
            if (in_valid && in_ready) begin
               for (int r = 0; r < 8; r++) begin
                  exp_t e;
                  e.d = qf(in_coeffs, 3'(r), in_is_luminance, in_quantize_off);
                  e.q = qq(3'(r), in_is_luminance, in_quantize_off);
                  e.r = 3'(r);
                  e.l = (r == 7);
                  sb.push_back(e);
               end
               cur_coeffs = in_coeffs;
               cur_luma   = in_is_luminance;
               cur_off    = in_quantize_off;
               t_acc      = cyc + 1;
               issue_cnt  = 0;
            end
         end
      end
   end

   // Minimal monitor for the QLAT=1 / DEPTH=3 build.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (in_valid2 && in_ready2) begin
               t_acc2   = cyc + 1;
               exp_row2 = 0;
            end
            if (out_valid2 && out_ready2) begin
               chk("i2_out_row", 96'(out_row2), 96'(exp_row2));
               chk("i2_out_data", 96'(out_data2), 96'(qf(blk2, 3'(exp_row2), 1'b1, 1'b0)));
               if (out_last2) t_last2 = cyc + 1;
               exp_row2++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send_block(input logic [767:0] blk, input logic luma, input logic off);
      in_coeffs       = blk;
      in_is_luminance = luma;
      in_quantize_off = off;
      in_valid        = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (in_ready) begin
            tick();
            in_valid = 1'b0;
            return;
         end
         tick();
      end
      in_valid = 1'b0;
      timeout("block_accept");
   endtask

   task automatic wait_idle(output int cn);
      cn = -1;
      for (int i = 0; i < 400; i++) begin
         if (in_ready) begin
            cn = cyc + 1;
            return;
         end
         tick();
      end
      timeout("return_to_idle");
   endtask

   function automatic logic [767:0] rand_block();
      logic [767:0] b;
      for (int k = 0; k < 24; k++) b[32*k +: 32] = $urandom;
      return b;
   endfunction

   initial begin
      logic [767:0] blk;
      int cn, t_a;
      reset = 1'b1; rand_mode = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
      in_valid = 1'b0; in_is_luminance = 1'b0; in_quantize_off = 1'b0; in_coeffs = '0;
      in_valid2 = 1'b0; in_coeffs2 = '0; blk2 = '0;
      issue_cnt = 0; t_acc = 0; t_acc2 = 0; t_last2 = 0; exp_row2 = 0;
      cur_coeffs = '0; cur_luma = 1'b0; cur_off = 1'b0;
      tick(); tick();
      chk("rst_in_ready", 96'(in_ready), 96'(0));
      chk("rst_q_issue", 96'(q_issue), 96'(0));
      chk("rst_q_matrix_row", 96'(q_matrix_row), 96'(0));
      chk("rst_q_coeffs_zero", 96'(q_dct_coeffs == '0), 96'(1));
      chk("rst_q_luma_off", 96'({q_is_luminance, q_quantize_off}), 96'(0));
      chk("rst_out", 96'({out_valid, out_row, out_last, out_quality, out_data}), 96'(0));
      chk("rst_busy", 96'(busy), 96'(0));
      chk("rst_in_ready2", 96'(in_ready2), 96'(0));
      reset = 1'b0;
      #1;
      chk("in_ready_after_reset", 96'(in_ready), 96'(1));

      // Single luma block, coeff = 16r+c, full-rate output.
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) blk[96*r + 12*c +: 12] = 12'(16*r + c);
      send_block(blk, 1'b1, 1'b0);
      wait_idle(cn);
      chk("t1_ready_return", 96'(cn - t_acc), 96'(10 + QLAT));
      chk("t1_first_issue", 96'(t_issue_first - t_acc), 96'(1));
      chk("t1_last_issue", 96'(t_issue_last - t_acc), 96'(8));
      chk("t1_row7_time", 96'(t_last_out - t_acc), 96'(9 + QLAT));
      chk("t1_row7_coeff7", 96'(last_data[79:70]), 96'(59));
      chk("t1_row7_quality", 96'(last_qual), 96'(8'hAF));

      // Backpressure: the credit limit stops issue at 4 rows.
      out_ready = 1'b0;
      send_block(rand_block(), 1'b0, 1'b0);
      repeat (20) tick();
      chk("bp_issue_count", 96'(issue_cnt), 96'(4));
      chk("bp_head_valid_row", 96'({out_valid, out_row}), 96'({1'b1, 3'd0}));
      out_ready = 1'b1;
      wait_idle(cn);
      chk("bp_all_issued", 96'(issue_cnt), 96'(8));

      // Three back-to-back blocks under random backpressure.
      rand_mode = 1'b1;
      send_block(rand_block(), 1'b1, 1'b0);
      send_block(rand_block(), 1'b0, 1'b1);
      send_block(rand_block(), 1'b1, 1'b0);
      wait_idle(cn);
      rand_mode = 1'b0;
      out_ready = 1'b1;
      chk("rand_sb_empty", 96'(sb.size()), 96'(0));

      // Reset mid-block after three issues.
      send_block(rand_block(), 1'b0, 1'b0);
      tick(); tick(); tick();
      chk("rst_mid_issues", 96'(issue_cnt), 96'(3));
      reset = 1'b1;
      #1;
      chk("rst_mid_q_issue", 96'(q_issue), 96'(0));
      tick();
      reset = 1'b0;
      chk("rst_mid_out_valid", 96'(out_valid), 96'(0));
      chk("rst_mid_busy", 96'(busy), 96'(0));
      tick(); tick(); tick();
      chk("rst_late_ignored", 96'(out_valid), 96'(0));
      send_block(rand_block(), 1'b1, 1'b1);
      wait_idle(cn);
      chk("rst_new_block_done", 96'(sb.size()), 96'(0));

      // New block held on in_valid during DRAIN.
      send_block(rand_block(), 1'b1, 1'b0);
      t_a = t_acc;
      send_block(rand_block(), 1'b0, 1'b0);
      chk("hold_accept_cycle", 96'(t_acc - t_a), 96'(10 + QLAT));
      wait_idle(cn);

      // QLAT=1, DEPTH=3 build.
      blk2 = rand_block();
      in_coeffs2 = blk2;
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      cn = -1;
      for (int i = 0; i < 100; i++) begin
         if (in_ready2) begin
            cn = cyc + 1;
            break;
         end
         tick();
      end
      if (cn < 0) timeout("i2_return_to_idle");
      chk("i2_row7_time", 96'(t_last2 - t_acc2), 96'(10));
      chk("i2_ready_return", 96'(cn - t_acc2), 96'(11));
      chk("i2_row_count", 96'(exp_row2), 96'(8));

      tick(); tick();
      chk("final_sb_empty", 96'(sb.size()), 96'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
